// File: rtl/alu_operand_stage.sv
// Registered operand select for the ALU input: NUM_IN-way mux into a two-entry skid buffer
// with valid/ready on both sides, out-of-range select flagging and an output transfer counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no beat buffered; in_ready=1, out_valid=0
// ST_ONE   | beat in output register; in_ready=1, out_valid=1
// ST_FULL  | beats in output and skid registers; in_ready=0, out_valid=1
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        xfer_cnt
);

    // Encoding is {out_valid, skid_valid} so both valids come straight off the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               out_err_q, out_err_d;
    logic               skid_err_q, skid_err_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   sel_data;
    logic               sel_hit;
    logic               accept;
    logic               xfer;

    // An out-of-range select matches no candidate, which yields zero data and the error flag.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    assign accept = in_valid && in_ready_q;
    assign xfer   = state_q[1] && out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        cnt_d       = cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (xfer) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_data_d = sel_data;
                        out_err_d  = !sel_hit;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer && accept) begin
                        out_data_d = sel_data;
                        out_err_d  = !sel_hit;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_data_d = sel_data;
                        skid_err_d  = !sel_hit;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        out_data_d = skid_data_q;
                        out_err_d  = skid_err_q;
                        state_d    = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= (state_d != ST_FULL);
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = state_q[1];
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a 4-input / 4-bit-counter instance for select, throughput,
// backpressure, flush, wrap and async reset, and a 3-input instance for the illegal select case.
module tb_alu_operand_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] m_data;
    logic [1:0]   m_sel;
    logic         m_valid, m_flush, m_oready;
    logic [31:0]  m_out;
    logic         m_err, m_ovalid, m_iready;
    logic [3:0]   m_cnt;

    logic [95:0]  e_data;
    logic [1:0]   e_sel;
    logic         e_valid, e_flush, e_oready;
    logic [31:0]  e_out;
    logic         e_err, e_ovalid, e_iready;
    logic [15:0]  e_cnt;

    alu_operand_stage #(.WIDTH(32), .NUM_IN(4), .CNT_W(4)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_data(m_data), .in_sel(m_sel), .in_valid(m_valid), .in_ready(m_iready),
        .flush(m_flush),
        .out_data(m_out), .out_err(m_err), .out_valid(m_ovalid), .out_ready(m_oready),
        .xfer_cnt(m_cnt)
    );

    alu_operand_stage #(.WIDTH(32), .NUM_IN(3), .CNT_W(16)) u_err (
        .clk(clk), .rst_n(rst_n),
        .in_data(e_data), .in_sel(e_sel), .in_valid(e_valid), .in_ready(e_iready),
        .flush(e_flush),
        .out_data(e_out), .out_err(e_err), .out_valid(e_ovalid), .out_ready(e_oready),
        .xfer_cnt(e_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        m_data = '0; m_sel = '0; m_valid = 1'b0; m_flush = 1'b0; m_oready = 1'b0;
        e_data = {32'hC2, 32'hC1, 32'hC0}; e_sel = '0; e_valid = 1'b0; e_flush = 1'b0; e_oready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_ovalid", 32'(m_ovalid), 32'd0);
        chk("rst_data", m_out, 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_cnt", 32'(m_cnt), 32'd0);
        chk("rst_iready", 32'(m_iready), 32'd1);
        rst_n = 1'b1;

        // basic select: candidate 1 then candidate 0
        @(negedge clk);
        m_data = {32'h0, 32'h0, 32'h12345678, 32'h87654321};
        m_oready = 1'b1; m_valid = 1'b1; m_sel = 2'd1;
        @(negedge clk);
        chk("basic_d1", m_out, 32'h12345678);
        chk("basic_v1", 32'(m_ovalid), 32'd1);
        chk("basic_e1", 32'(m_err), 32'd0);
        m_sel = 2'd0;
        @(negedge clk);
        chk("basic_d0", m_out, 32'h87654321);
        chk("basic_v0", 32'(m_ovalid), 32'd1);
        m_valid = 1'b0;
        @(negedge clk);
        chk("basic_idle", 32'(m_ovalid), 32'd0);
        chk("basic_cnt", 32'(m_cnt), 32'd2);

        // back-to-back sweep over all candidates
        m_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        m_valid = 1'b1; m_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sweep_d%0d", i), m_out, 32'hA0 + 32'(i));
            chk($sformatf("sweep_v%0d", i), 32'(m_ovalid), 32'd1);
            chk($sformatf("sweep_r%0d", i), 32'(m_iready), 32'd1);
            if (i == 3) m_valid = 1'b0;
            else m_sel = 2'(i + 1);
        end
        @(negedge clk);
        chk("sweep_idle", 32'(m_ovalid), 32'd0);
        chk("sweep_cnt", 32'(m_cnt), 32'd6);

        // backpressure: 0x11 to output, 0x22 to skid, 0x33 held upstream
        m_oready = 1'b0; m_sel = 2'd0;
        m_data = {32'h0, 32'h0, 32'h0, 32'h11}; m_valid = 1'b1;
        @(negedge clk);
        chk("bp_d11", m_out, 32'h11);
        chk("bp_r1", 32'(m_iready), 32'd1);
        m_data[31:0] = 32'h22;
        @(negedge clk);
        chk("bp_hold1", m_out, 32'h11);
        chk("bp_r0", 32'(m_iready), 32'd0);
        m_data[31:0] = 32'h33;
        @(negedge clk);
        chk("bp_hold2", m_out, 32'h11);
        chk("bp_r0b", 32'(m_iready), 32'd0);
        chk("bp_v", 32'(m_ovalid), 32'd1);
        m_oready = 1'b1;
        @(negedge clk);
        chk("bp_d22", m_out, 32'h22);
        chk("bp_r1b", 32'(m_iready), 32'd1);
        @(negedge clk);
        chk("bp_d33", m_out, 32'h33);
        m_valid = 1'b0;
        @(negedge clk);
        chk("bp_idle", 32'(m_ovalid), 32'd0);
        chk("bp_cnt", 32'(m_cnt), 32'd9);

        // flush while FULL, with accept and transfer requested in the same cycle
        m_oready = 1'b0; m_data[31:0] = 32'h44; m_valid = 1'b1;
        @(negedge clk);
        m_data[31:0] = 32'h55;
        @(negedge clk);
        chk("fl_full_r", 32'(m_iready), 32'd0);
        chk("fl_full_v", 32'(m_ovalid), 32'd1);
        m_flush = 1'b1; m_oready = 1'b1;
        @(negedge clk);
        chk("fl_v", 32'(m_ovalid), 32'd0);
        chk("fl_r", 32'(m_iready), 32'd1);
        chk("fl_cnt", 32'(m_cnt), 32'd9);
        m_flush = 1'b0; m_valid = 1'b0;

        // illegal select on the 3-input instance, then a legal beat
        e_valid = 1'b1; e_sel = 2'd3;
        @(negedge clk);
        chk("ill_d", e_out, 32'd0);
        chk("ill_e", 32'(e_err), 32'd1);
        chk("ill_v", 32'(e_ovalid), 32'd1);
        e_sel = 2'd2;
        @(negedge clk);
        chk("leg_d", e_out, 32'hC2);
        chk("leg_e", 32'(e_err), 32'd0);
        e_valid = 1'b0;
        @(negedge clk);
        chk("ill_idle", 32'(e_ovalid), 32'd0);
        chk("ill_cnt", 32'(e_cnt), 32'd2);

        // counter wrap: 17 transfers on a 4-bit counter from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_data[31:0] = 32'h66; m_sel = 2'd0; m_oready = 1'b1; m_valid = 1'b1;
        repeat (17) @(negedge clk);
        chk("wrap_16", 32'(m_cnt), 32'd0);
        m_valid = 1'b0;
        @(negedge clk);
        chk("wrap_17", 32'(m_cnt), 32'd1);
        chk("wrap_idle", 32'(m_ovalid), 32'd0);

        // async reset between edges with both entries occupied
        m_oready = 1'b0; m_data[31:0] = 32'hBEEF; m_valid = 1'b1;
        @(negedge clk);
        chk("ar_pre_d", m_out, 32'hBEEF);
        @(negedge clk);
        chk("ar_pre_r", 32'(m_iready), 32'd0);
        m_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_v", 32'(m_ovalid), 32'd0);
        chk("ar_d", m_out, 32'd0);
        chk("ar_e", 32'(m_err), 32'd0);
        chk("ar_cnt", 32'(m_cnt), 32'd0);
        chk("ar_r", 32'(m_iready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
